// File: rtl/snake_pkg.sv
// Shared direction codes, FSM state encoding and helpers for the snake body engine.
package snake_pkg;

    localparam logic [1:0] DIR_RIGHT = 2'b00;
    localparam logic [1:0] DIR_LEFT  = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_UP    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_MOVE,
        S_SCAN,
        S_COMMIT,
        S_DRAW
    } state_t;

    // Opposite directions differ only in bit 0 (right/left, down/up).
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return {d[1], ~d[0]};
    endfunction

endpackage

// File: rtl/snake_seg_ram.sv
// Single-port synchronous segment RAM: write-first, one-cycle registered read.
module snake_seg_ram #(
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int DW    = 11
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body engine: circular buffer of cell coordinates in sync RAM, head/tail pointers,
// init/step/draw command FSM with wall, self-collision and food handling.
module snake_body_engine
    import snake_pkg::*;
#(
    parameter int GRID_W   = 40,
    parameter int GRID_H   = 30,
    parameter int XW       = 6,
    parameter int YW       = 5,
    parameter int MAX_LEN  = 64,
    parameter int AW       = 6,
    parameter int INIT_LEN = 3,
    parameter int START_X  = 15,
    parameter int START_Y  = 15,
    parameter int WRAP     = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step,
    input  logic [1:0]    dir,
    input  logic [XW-1:0] food_x,
    input  logic [YW-1:0] food_y,
    input  logic          draw_req,
    input  logic          seg_ready,
    output logic          seg_valid,
    output logic [XW-1:0] seg_x,
    output logic [YW-1:0] seg_y,
    output logic          seg_head,
    output logic          seg_last,
    output logic          busy,
    output logic          done,
    output logic          ate,
    output logic          dead,
    output logic [AW:0]   length
);

    localparam logic [AW:0] LEN_MAX = (AW+1)'(MAX_LEN);

    state_t        state, state_n;
    logic [AW-1:0] head_ptr, tail_ptr;
    logic [AW:0]   cnt, n_cmp;
    logic [1:0]    cur_dir;
    logic [XW-1:0] head_x, nh_x;
    logic [YW-1:0] head_y, nh_y;
    logic          hit, on_food, grow;

    logic             ram_we;
    logic [AW-1:0]    ram_addr;
    logic [XW+YW-1:0] ram_wdata, ram_rdata;

    logic [1:0]    eff_dir;
    logic [XW-1:0] mv_x;
    logic [YW-1:0] mv_y;
    logic          mv_out, mv_food, mv_grow, scan_cmp, draw_last;

    snake_seg_ram #(.DEPTH(MAX_LEN), .AW(AW), .DW(XW+YW)) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    // Candidate head; mv_out flags a grid exit, mv_x/mv_y already hold the wrapped cell.
    always_comb begin
        eff_dir = (dir == opposite_dir(cur_dir)) ? cur_dir : dir;
        mv_x    = head_x;
        mv_y    = head_y;
        mv_out  = 1'b0;
        case (eff_dir)
            DIR_RIGHT: if (head_x == XW'(GRID_W - 1)) begin mv_out = 1'b1; mv_x = '0; end
                       else mv_x = head_x + 1'b1;
            DIR_LEFT:  if (head_x == '0) begin mv_out = 1'b1; mv_x = XW'(GRID_W - 1); end
                       else mv_x = head_x - 1'b1;
            DIR_DOWN:  if (head_y == YW'(GRID_H - 1)) begin mv_out = 1'b1; mv_y = '0; end
                       else mv_y = head_y + 1'b1;
            default:   if (head_y == '0) begin mv_out = 1'b1; mv_y = YW'(GRID_H - 1); end
                       else mv_y = head_y - 1'b1;
        endcase
        mv_food = ({mv_x, mv_y} == {food_x, food_y});
        mv_grow = mv_food && (length < LEN_MAX);
    end

    // In SCAN, rdata at count k holds body slot k-1 (read issued the previous cycle).
    assign scan_cmp  = (cnt != '0) && (ram_rdata == {nh_x, nh_y});
    assign draw_last = ((head_ptr + cnt[AW-1:0]) == tail_ptr);

    assign busy      = (state != S_IDLE);
    assign seg_valid = (state == S_DRAW);
    assign seg_head  = seg_valid && (cnt == '0);
    assign seg_last  = seg_valid && draw_last;
    assign seg_x     = seg_valid ? ram_rdata[XW+YW-1:YW] : '0;
    assign seg_y     = seg_valid ? ram_rdata[YW-1:0] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        ram_we    = 1'b0;
        ram_addr  = head_ptr;
        ram_wdata = {nh_x, nh_y};
        case (state)
            S_IDLE: begin
                if (start)                                      state_n = S_INIT;
                else if (step && (length != '0) && !dead)       state_n = S_MOVE;
                else if (draw_req && (length != '0))            state_n = S_DRAW;
            end
            S_INIT: begin
                ram_we    = 1'b1;
                ram_addr  = cnt[AW-1:0];
                ram_wdata = {XW'(START_X) - XW'(cnt), YW'(START_Y)};
                if (cnt == (AW+1)'(INIT_LEN - 1)) state_n = S_IDLE;
            end
            S_MOVE: state_n = (mv_out && (WRAP == 0)) ? S_IDLE : S_SCAN;
            S_SCAN: begin
                ram_addr = head_ptr + cnt[AW-1:0];
                if (cnt == n_cmp) state_n = S_COMMIT;
            end
            S_COMMIT: begin
                ram_we   = !hit;
                ram_addr = head_ptr - 1'b1;
                state_n  = S_IDLE;
            end
            S_DRAW: begin
                // Prefetch the next slot on acceptance so the stream has no bubbles.
                ram_addr = head_ptr + cnt[AW-1:0] + AW'(seg_ready);
                if (seg_ready && draw_last) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            length   <= '0;
            cnt      <= '0;
            n_cmp    <= '0;
            cur_dir  <= DIR_RIGHT;
            head_x   <= '0;
            head_y   <= '0;
            nh_x     <= '0;
            nh_y     <= '0;
            hit      <= 1'b0;
            on_food  <= 1'b0;
            grow     <= 1'b0;
            dead     <= 1'b0;
            done     <= 1'b0;
            ate      <= 1'b0;
        end else begin
            done <= 1'b0;
            ate  <= 1'b0;
            case (state)
                S_IDLE: cnt <= '0;
                S_INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == (AW+1)'(INIT_LEN - 1)) begin
                        head_ptr <= '0;
                        tail_ptr <= AW'(INIT_LEN - 1);
                        length   <= (AW+1)'(INIT_LEN);
                        cur_dir  <= DIR_RIGHT;
                        head_x   <= XW'(START_X);
                        head_y   <= YW'(START_Y);
                        dead     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                S_MOVE: begin
                    cur_dir <= eff_dir;
                    nh_x    <= mv_x;
                    nh_y    <= mv_y;
                    on_food <= mv_food;
                    grow    <= mv_grow;
                    n_cmp   <= mv_grow ? length : length - 1'b1;
                    hit     <= 1'b0;
                    cnt     <= '0;
                    if (mv_out && (WRAP == 0)) begin
                        dead <= 1'b1;
                        done <= 1'b1;
                    end
                end
                S_SCAN: begin
                    cnt <= cnt + 1'b1;
                    if (scan_cmp) hit <= 1'b1;
                end
                S_COMMIT: begin
                    done <= 1'b1;
                    if (hit) begin
                        dead <= 1'b1;
                    end else begin
                        head_ptr <= head_ptr - 1'b1;
                        head_x   <= nh_x;
                        head_y   <= nh_y;
                        ate      <= on_food;
                        if (grow) length   <= length + 1'b1;
                        else      tail_ptr <= tail_ptr - 1'b1;
                    end
                end
                S_DRAW: begin
                    if (seg_ready) begin
                        cnt <= cnt + 1'b1;
                        if (draw_last) done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_body_engine.sv
// Randomised and directed check of snake_body_engine (WRAP=0 and WRAP=1 instances)
// against a shift-array body model.
module tb_snake_body_engine;

    localparam int XW = 6;
    localparam int YW = 5;
    localparam int AW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          start [2];
    logic          step [2];
    logic          draw_req [2];
    logic          seg_ready [2];
    logic [1:0]    dir [2];
    logic [XW-1:0] food_x [2];
    logic [YW-1:0] food_y [2];
    logic          seg_valid [2];
    logic [XW-1:0] seg_x [2];
    logic [YW-1:0] seg_y [2];
    logic          seg_head [2];
    logic          seg_last [2];
    logic          busy [2];
    logic          done [2];
    logic          ate [2];
    logic          dead [2];
    logic [AW:0]   length [2];

    snake_body_engine #(.WRAP(0)) dut (
        .clk(clk), .rst(rst), .start(start[0]), .step(step[0]), .dir(dir[0]),
        .food_x(food_x[0]), .food_y(food_y[0]), .draw_req(draw_req[0]),
        .seg_ready(seg_ready[0]), .seg_valid(seg_valid[0]), .seg_x(seg_x[0]),
        .seg_y(seg_y[0]), .seg_head(seg_head[0]), .seg_last(seg_last[0]),
        .busy(busy[0]), .done(done[0]), .ate(ate[0]), .dead(dead[0]), .length(length[0])
    );

    snake_body_engine #(.WRAP(1)) dut_wrap (
        .clk(clk), .rst(rst), .start(start[1]), .step(step[1]), .dir(dir[1]),
        .food_x(food_x[1]), .food_y(food_y[1]), .draw_req(draw_req[1]),
        .seg_ready(seg_ready[1]), .seg_valid(seg_valid[1]), .seg_x(seg_x[1]),
        .seg_y(seg_y[1]), .seg_head(seg_head[1]), .seg_last(seg_last[1]),
        .busy(busy[1]), .done(done[1]), .ate(ate[1]), .dead(dead[1]), .length(length[1])
    );

    // Reference body: index 0 is the head, entries shift toward the tail on each move.
    int bx [2][64];
    int by [2][64];
    int mlen [2];
    int mdir [2];
    bit mdead [2];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_start(input int u);
        mlen[u] = 3; mdir[u] = 0; mdead[u] = 1'b0;
        for (int i = 0; i < 3; i++) begin bx[u][i] = 15 - i; by[u][i] = 15; end
    endtask

    task automatic next_cell(input int u, input int d, output int eff, output int nx,
                             output int ny, output bit wall);
        eff = (d == (mdir[u] ^ 1)) ? mdir[u] : d;
        nx = bx[u][0]; ny = by[u][0];
        case (eff)
            0: nx++;
            1: nx--;
            2: ny++;
            default: ny--;
        endcase
        wall = 1'b0;
        if (nx < 0 || nx >= 40 || ny < 0 || ny >= 30) begin
            if (u == 0) wall = 1'b1;
            else begin nx = (nx + 40) % 40; ny = (ny + 30) % 30; end
        end
    endtask

    task automatic wait_done(input int u, input int bound, output bit got, output int lat,
                             output bit a);
        got = 1'b0; lat = 0; a = 1'b0;
        for (int c = 1; c <= bound; c++) begin
            @(posedge clk); #1;
            if (done[u]) begin got = 1'b1; lat = c; a = ate[u]; break; end
        end
    endtask

    task automatic run_start(input int u);
        bit got, a; int lat;
        start[u] = 1'b1;
        @(posedge clk); #1;
        start[u] = 1'b0;
        wait_done(u, 40, got, lat, a);
        model_start(u);
        check("start_done", int'(got), 1);
        check("start_lat", lat, 3);
        check("start_dead", int'(dead[u]), 0);
        check("start_len", int'(length[u]), mlen[u]);
    endtask

    task automatic run_step(input int u, input int d, input int fx, input int fy);
        int eff, nx, ny, n, lat;
        bit wall, food, grow, hit, got, a, ign;
        ign = (mlen[u] == 0) || mdead[u];
        next_cell(u, d, eff, nx, ny, wall);
        food_x[u] = XW'(fx); food_y[u] = YW'(fy); dir[u] = 2'(d);
        step[u] = 1'b1;
        @(posedge clk); #1;
        step[u] = 1'b0;
        wait_done(u, ign ? 8 : 100, got, lat, a);
        if (ign) begin
            check("ignored_step", int'(got), 0);
            check("ignored_busy", int'(busy[u]), 0);
            return;
        end
        check("step_done", int'(got), 1);
        if (wall) begin
            mdead[u] = 1'b1;
            check("wall_ate", int'(a), 0);
        end else begin
            food = (nx == fx) && (ny == fy);
            grow = food && (mlen[u] < 64);
            n = grow ? mlen[u] : mlen[u] - 1;
            hit = 1'b0;
            for (int i = 0; i < n; i++) if (bx[u][i] == nx && by[u][i] == ny) hit = 1'b1;
            check("step_lat", lat, n + 3);
            mdir[u] = eff;
            if (hit) begin
                mdead[u] = 1'b1;
                food = 1'b0;
            end else begin
                for (int i = 63; i > 0; i--) begin bx[u][i] = bx[u][i-1]; by[u][i] = by[u][i-1]; end
                bx[u][0] = nx; by[u][0] = ny;
                if (grow) mlen[u]++;
            end
            check("ate", int'(a), int'(food));
        end
        check("dead", int'(dead[u]), int'(mdead[u]));
        check("length", int'(length[u]), mlen[u]);
    endtask

    // mode 0: always ready, 1: ready every other cycle, 2: random ready
    task automatic run_draw(input int u, input int mode);
        int n, exp, got;
        bit fin;
        draw_req[u] = 1'b1;
        @(posedge clk); #1;
        draw_req[u] = 1'b0;
        n = 0; fin = 1'b0;
        for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
            seg_ready[u] = (mode == 0) ? 1'b1 : (mode == 1) ? 1'((cyc % 2) == 1)
                                                             : 1'($urandom_range(0, 1));
            #1;
            if (done[u]) fin = 1'b1;
            else begin
                if (seg_valid[u]) begin
                    got = int'({seg_head[u], seg_last[u], seg_x[u], seg_y[u]});
                    exp = (n < 64) ? (((n == 0) ? 1 : 0) << 12) | (((n == mlen[u] - 1) ? 1 : 0) << 11)
                                     | (bx[u][n] << 5) | by[u][n]
                                   : -1;
                    check("seg", got, exp);
                    if (seg_ready[u]) n++;
                end
                @(posedge clk); #1;
            end
        end
        seg_ready[u] = 1'b0;
        check("draw_done", int'(fin), 1);
        check("draw_count", n, mlen[u]);
    endtask

    initial begin
        bit got, a, wall;
        int lat, eff, nx, ny, d, fx, fy;
        for (int u = 0; u < 2; u++) begin
            start[u] = 1'b0; step[u] = 1'b0; draw_req[u] = 1'b0; seg_ready[u] = 1'b0;
            dir[u] = '0; food_x[u] = '0; food_y[u] = '0;
            mlen[u] = 0; mdir[u] = 0; mdead[u] = 1'b0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("rst_busy", int'(busy[u]), 0);
            check("rst_done", int'(done[u]), 0);
            check("rst_dead", int'(dead[u]), 0);
            check("rst_len", int'(length[u]), 0);
            check("rst_valid", int'(seg_valid[u]), 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;

        run_step(0, 0, 0, 0);

        // Reset in the middle of INIT aborts back to an empty idle engine.
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        check("init_busy", int'(busy[0]), 1);
        rst = 1'b1; #1;
        check("abort_busy", int'(busy[0]), 0);
        check("abort_len", int'(length[0]), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_start(0);
        run_draw(0, 0);
        run_step(0, 2, 0, 0);
        run_draw(0, 0);

        run_start(0);
        run_step(0, 0, 16, 15);
        run_draw(0, 0);
        run_step(0, 0, 17, 15);
        run_step(0, 2, 0, 0);
        run_step(0, 1, 0, 0);
        run_step(0, 3, 0, 0);
        check("self_hit_dead", int'(dead[0]), 1);
        run_step(0, 2, 0, 0);
        run_draw(0, 0);
        run_start(0);

        // start outranks step when both arrive together.
        start[0] = 1'b1; step[0] = 1'b1; dir[0] = 2'd2;
        @(posedge clk); #1;
        start[0] = 1'b0; step[0] = 1'b0;
        wait_done(0, 40, got, lat, a);
        model_start(0);
        check("prio_lat", lat, 3);
        check("prio_len", int'(length[0]), 3);
        run_draw(0, 0);

        for (int u = 0; u < 2; u++) begin
            run_start(u);
            for (int k = 0; k < 25; k++) run_step(u, 0, 0, 0);
            run_draw(u, 1);
        end

        run_start(0);
        for (int k = 0; k < 66; k++) begin
            if (by[0][0] % 2 == 1) d = (bx[0][0] == 39) ? 2 : 0;
            else                   d = (bx[0][0] == 0) ? 2 : 1;
            next_cell(0, d, eff, nx, ny, wall);
            run_step(0, d, nx, ny);
        end
        check("full_len", int'(length[0]), 64);
        run_draw(0, 1);

        for (int u = 0; u < 2; u++) begin
            run_start(u);
            for (int it = 0; it < 150; it++) begin
                if (mdead[u]) begin
                    if ($urandom_range(0, 2) == 0) run_step(u, 0, 0, 0);
                    run_start(u);
                end else begin
                    d = int'($urandom_range(0, 3));
                    next_cell(u, d, eff, nx, ny, wall);
                    if (!wall && $urandom_range(0, 1) == 1) begin fx = nx; fy = ny; end
                    else begin fx = int'($urandom_range(0, 39)); fy = int'($urandom_range(0, 29)); end
                    run_step(u, d, fx, fy);
                end
                if ($urandom_range(0, 11) == 0) run_draw(u, 2);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
